// File: rtl/parity_step_counter.sv
// Even/odd/binary up/down step counter with synchronous load, wrap pulse and parity status.
// A misaligned count (wrong parity for the mode) always takes a single +/-1 step to realign.
module parity_step_counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             parity_ok
);

    typedef enum logic [1:0] {
        MODE_EVEN = 2'b00,
        MODE_ODD  = 2'b01,
        MODE_BIN  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        ALIGNED    = 1'b0,
        MISALIGNED = 1'b1
    } align_e;

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   STEP_ONE  = {{(WIDTH-1){1'b0}}, 2'b01};
    localparam logic [WIDTH:0]   STEP_TWO  = {{(WIDTH-1){1'b0}}, 2'b10};

    function automatic logic parity_match(input logic lsb, input mode_e m);
        logic res;
        case (m)
            MODE_EVEN: res = (lsb == 1'b0);
            MODE_ODD:  res = (lsb == 1'b1);
            MODE_BIN:  res = 1'b1;
            MODE_HOLD: res = 1'b1;
            default:   res = 1'b1;
        endcase
        return res;
    endfunction

    mode_e            mode_s;
    align_e           align_s;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   sum_s;
    logic             advance_s;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             parity_ok_q;
    logic             parity_ok_d;

    assign mode_s = mode_e'(mode);

    // Alignment of the current count against the requested parity.
    always_comb begin
        align_s = ALIGNED;
        case (mode_s)
            MODE_EVEN: align_s = count_q[0] ? MISALIGNED : ALIGNED;
            MODE_ODD:  align_s = count_q[0] ? ALIGNED : MISALIGNED;
            MODE_BIN:  align_s = ALIGNED;
            MODE_HOLD: align_s = ALIGNED;
            default:   align_s = ALIGNED;
        endcase
    end

    // Step size and one-bit-extended sum; the extra bit is the carry/borrow that flags a wrap.
    always_comb begin
        step_s = STEP_ONE;
        sum_s  = {1'b0, count_q};
        if ((mode_s == MODE_BIN) || (align_s == MISALIGNED)) begin
            step_s = STEP_ONE;
        end else begin
            step_s = STEP_TWO;
        end
        if (dir) begin
            sum_s = {1'b0, count_q} + step_s;
        end else begin
            sum_s = {1'b0, count_q} - step_s;
        end
    end

    assign advance_s = en && (mode_s != MODE_HOLD);

    // Next-state selection: load beats an enabled step, which beats hold.
    always_comb begin
        count_d     = count_q;
        wrap_d      = 1'b0;
        parity_ok_d = 1'b1;
        if (load) begin
            count_d = load_val;
            wrap_d  = 1'b0;
        end else if (advance_s) begin
            count_d = sum_s[WIDTH-1:0];
            wrap_d  = sum_s[WIDTH];
        end else begin
            count_d = count_q;
            wrap_d  = 1'b0;
        end
        parity_ok_d = parity_match(count_d[0], mode_s);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= RST_COUNT;
            wrap_q      <= 1'b0;
            parity_ok_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            parity_ok_q <= parity_ok_d;
        end
    end

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign parity_ok = parity_ok_q;

endmodule

// File: tb/tb_parity_step_counter.sv
// Bench for parity_step_counter: directed scenarios plus random traffic on a 3-bit and an 8-bit instance,
// both compared every cycle against an integer model of the stepping rules.
module tb_parity_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [1:0] mode;
    logic       dir;
    logic [2:0] lv3;
    logic [7:0] lv8;

    logic [2:0] count3;
    logic       wrap3;
    logic       pok3;
    logic [7:0] count8;
    logic       wrap8;
    logic       pok8;

    int total = 0;
    int bad   = 0;

    int m3c, m8c;
    bit m3w, m8w, m3p, m8p;

    always #5 clk = ~clk;

    parity_step_counter #(.WIDTH(3), .RST_VAL(0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv3),
        .mode(mode), .dir(dir), .count(count3), .wrap(wrap3), .parity_ok(pok3)
    );

    parity_step_counter #(.WIDTH(8), .RST_VAL(0)) dut8 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv8),
        .mode(mode), .dir(dir), .count(count8), .wrap(wrap8), .parity_ok(pok8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Mode 0 wants even (parity 0), mode 1 wants odd (parity 1), 2 is binary, 3 holds.
    task automatic model_step(inout int c, inout bit w, inout bit p, input int m_size, input int lv);
        int delta;
        int t;
        if (load) begin
            c = lv;
            w = 1'b0;
        end else if (en && mode != 2'd3) begin
            if (mode == 2'd2) delta = 1;
            else if ((c % 2) == int'(mode)) delta = 2;
            else delta = 1;
            t = dir ? c + delta : c - delta;
            w = (t >= m_size) || (t < 0);
            c = (t + m_size) % m_size;
        end else begin
            w = 1'b0;
        end
        p = (mode >= 2'd2) ? 1'b1 : ((c % 2) == int'(mode));
    endtask

    task automatic tick(input string tag);
        model_step(m3c, m3w, m3p, 8, int'(lv3));
        model_step(m8c, m8w, m8p, 256, int'(lv8));
        @(posedge clk);
        #1;
        chk({tag, "/cnt3"}, 32'(count3), 32'(m3c));
        chk({tag, "/wrap3"}, 32'(wrap3), 32'(m3w));
        chk({tag, "/pok3"}, 32'(pok3), 32'(m3p));
        chk({tag, "/cnt8"}, 32'(count8), 32'(m8c));
        chk({tag, "/wrap8"}, 32'(wrap8), 32'(m8w));
        chk({tag, "/pok8"}, 32'(pok8), 32'(m8p));
    endtask

    // Called a little after a posedge: assert reset, check the async clear before any edge, release on negedge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "/rst_cnt3"}, 32'(count3), 32'd0);
        chk({tag, "/rst_wrap3"}, 32'(wrap3), 32'd0);
        chk({tag, "/rst_cnt8"}, 32'(count8), 32'd0);
        chk({tag, "/rst_wrap8"}, 32'(wrap8), 32'd0);
        m3c = 0; m3w = 1'b0;
        m8c = 0; m8w = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; mode = 2'd0; dir = 1'b1;
        lv3 = 3'd0; lv8 = 8'd0;
        m3c = 0; m8c = 0; m3w = 1'b0; m8w = 1'b0; m3p = 1'b1; m8p = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/cnt3", 32'(count3), 32'd0);
        chk("reset/wrap3", 32'(wrap3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick("idle");

        // T1: binary up to 5, then async reset mid-count.
        mode = 2'd2; dir = 1'b1; en = 1'b1;
        repeat (5) tick("t1_bin");
        chk("t1/at5", 32'(count3), 32'd5);
        async_reset("t1");

        // T2: odd up from 0 -> 1,3,5,7,1 with wrap on the last step.
        mode = 2'd1; dir = 1'b1; en = 1'b1;
        repeat (5) tick("t2_odd_up");
        chk("t2/end_cnt", 32'(count3), 32'd1);
        chk("t2/end_wrap", 32'(wrap3), 32'd1);

        // T3: load 6, even down -> 4,2,0,6,4.
        load = 1'b1; lv3 = 3'd6; lv8 = 8'd6;
        tick("t3_load");
        load = 1'b0; mode = 2'd0; dir = 1'b0;
        repeat (3) tick("t3_even_dn");
        tick("t3_wrap_step");
        chk("t3/wrap_6", 32'(wrap3), 32'd1);
        tick("t3_after");

        // T4: misaligned load of 3 in EVEN, realign up to 4, then 6, 0 with wrap.
        load = 1'b1; en = 1'b0; lv3 = 3'd3; lv8 = 8'd3; dir = 1'b1;
        tick("t4_load");
        chk("t4/pok_mis", 32'(pok3), 32'd0);
        load = 1'b0; en = 1'b1;
        repeat (3) tick("t4_realign");
        chk("t4/wrap0", 32'(wrap3), 32'd1);

        // T5: load wins over en, then hold via en=0 and via mode HOLD.
        load = 1'b1; en = 1'b1; lv3 = 3'd5; lv8 = 8'd5;
        tick("t5_load");
        load = 1'b0; en = 1'b0;
        repeat (3) tick("t5_en0");
        mode = 2'd3; en = 1'b1;
        repeat (2) tick("t5_hold");
        chk("t5/held", 32'(count3), 32'd5);

        // T6: alternating ODD/EVEN every clock from 0.
        load = 1'b1; lv3 = 3'd0; lv8 = 8'd0;
        tick("t6_load");
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mode = (i % 2 == 0) ? 2'd1 : 2'd0;
            tick("t6_alt");
        end

        // 8-bit wrap smoke: BIN up 255 -> 0.
        load = 1'b1; lv8 = 8'd255; lv3 = 3'd7; mode = 2'd2;
        tick("w8_load");
        load = 1'b0;
        tick("w8_wrap");
        chk("w8/cnt", 32'(count8), 32'd0);
        chk("w8/wrap", 32'(wrap8), 32'd1);

        // Random traffic, with one mid-run reset.
        for (int i = 0; i < 300; i++) begin
            en   = 1'($urandom_range(0, 3) != 0);
            load = 1'($urandom_range(0, 7) == 0);
            mode = 2'($urandom_range(0, 3));
            dir  = 1'($urandom_range(0, 1));
            lv3  = 3'($urandom_range(0, 7));
            lv8  = 8'($urandom_range(0, 255));
            tick("rand");
            if (i == 150) async_reset("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
